seq_divider: RTL and testbench

Iterative multi-cycle integer divider for the pipelined ALU datapath, the inverse counterpart of the carry-lookahead add/subtract slices. It computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, with a restoring shift-subtract algorithm at one quotient bit per clock. The pipeline stalls on `busy`, captures results on `done`, and issues a new `start` afterwards.

---
 rtl/seq_divider_if.sv | 20 ++
 rtl/seq_divider.sv | 73 +++++++
 tb/tb_seq_divider.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: request and result bus of the iterative divider.
interface seq_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clock, signed or unsigned.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dvs, r_q, r_r;
  logic [WIDTH:0]   w_shift, w_trial;
  logic [CW-1:0]    r_cnt;
  logic             r_qsign, r_rsign, r_zero, r_dz;
  logic             w_accept, w_dvd_neg, w_dvs_neg;
  always_comb begin
    w_accept  = (r_state == IDLE || r_state == DONE) && bus.start;
    w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    w_shift   = {r_rem, r_dvd[WIDTH-1]};
    w_trial   = w_shift - {1'b0, r_dvs};
    w_next    = r_state;
    if (w_accept) w_next = RUN;
    else if (r_state == DONE) w_next = IDLE;
    else if (r_state == RUN) w_next = (r_cnt == '0) ? FIX : RUN;
    else if (r_state == FIX) w_next = DONE;
  end
  // r_dvd shifts the dividend out at the top while quotient bits enter at the bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_zero  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rem   <= '0;
        r_dvd   <= w_dvd_neg ? -bus.dividend : bus.dividend;
        r_dvs   <= w_dvs_neg ? -bus.divisor : bus.divisor;
        r_cnt   <= CW'(WIDTH - 1);
        r_qsign <= w_dvd_neg ^ w_dvs_neg;
        r_rsign <= w_dvd_neg;
        r_zero  <= bus.divisor == '0;
        r_q     <= '0;
        r_r     <= '0;
        r_dz    <= 1'b0;
      end else if (r_state == RUN) begin
        r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == FIX) begin
        // with a zero divisor every trial succeeds, so the remainder is |dividend| and re-signs to the original
        r_q  <= r_zero ? '1 : (r_qsign ? -r_dvd : r_dvd);
        r_r  <= r_rsign ? -r_rem : r_rem;
        r_dz <= r_zero;
      end
    end
  end
  assign bus.busy        = r_state == RUN || r_state == FIX;
  assign bus.done        = r_state == DONE;
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of results, latency, busy/done timing, start filtering and reset abort.
module tb_seq_divider;
  logic clk, rst_n;
  int   checks, errors, cyc, t0, lat, nb, ndone;
  seq_divider_if #(.WIDTH(32)) dif ();
  seq_divider #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.start = 1'b1;
    dif.is_signed = s;
    dif.dividend = a;
    dif.divisor = b;
    @(posedge clk);
    #1;
    t0 = cyc;
    dif.start = 1'b0;
  endtask
  task automatic wait_done(output int l, output int n);
    n = 0;
    while (!dif.done && cyc - t0 < 100) begin
      if (dif.busy) n++;
      @(posedge clk);
      #1;
    end
    l = cyc - t0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    dif.start = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_q", dif.quotient, 32'd0);
    chk("rst_r", dif.remainder, 32'd0);
    chk("rst_dz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 32'd100, 32'd7);
    chk("u100_busy_e0", 32'(dif.busy), 32'd1);
    wait_done(lat, nb);
    chk("u100_lat", 32'(lat), 32'd33);
    chk("u100_busy_cycles", 32'(nb), 32'd33);
    chk("u100_busy_in_done", 32'(dif.busy), 32'd0);
    chk("u100_q", dif.quotient, 32'd14);
    chk("u100_r", dif.remainder, 32'd2);
    chk("u100_dz", 32'(dif.div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    chk("u100_done_pulse", 32'(dif.done), 32'd0);
    chk("u100_q_held", dif.quotient, 32'd14);
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, nb);
    chk("s_m7_q", dif.quotient, 32'hFFFF_FFFD);
    chk("s_m7_r", dif.remainder, 32'hFFFF_FFFF);
    start_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, nb);
    chk("u_m7_q", dif.quotient, 32'h7FFF_FFFC);
    chk("u_m7_r", dif.remainder, 32'd1);
    start_op(1'b1, 32'h1234_5678, 32'd0);
    wait_done(lat, nb);
    chk("dz_lat", 32'(lat), 32'd33);
    chk("dz_q", dif.quotient, 32'hFFFF_FFFF);
    chk("dz_r", dif.remainder, 32'h1234_5678);
    chk("dz_flag", 32'(dif.div_by_zero), 32'd1);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, nb);
    chk("ovf_s_q", dif.quotient, 32'h8000_0000);
    chk("ovf_s_r", dif.remainder, 32'd0);
    chk("ovf_s_dz", 32'(dif.div_by_zero), 32'd0);
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, nb);
    chk("ovf_u_q", dif.quotient, 32'd0);
    chk("ovf_u_r", dif.remainder, 32'h8000_0000);
    start_op(1'b0, 32'd1000, 32'd10);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    dif.start = 1'b1;
    dif.dividend = 32'd50;
    dif.divisor = 32'd5;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done(lat, nb);
    chk("ign_lat", 32'(lat), 32'd33);
    chk("ign_q", dif.quotient, 32'd100);
    chk("ign_r", dif.remainder, 32'd0);
    dif.start = 1'b1;
    dif.dividend = 32'd77;
    dif.divisor = 32'd5;
    @(posedge clk);
    #1;
    t0 = cyc;
    dif.start = 1'b0;
    chk("b2b_busy", 32'(dif.busy), 32'd1);
    chk("b2b_q_clear", dif.quotient, 32'd0);
    wait_done(lat, nb);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_q", dif.quotient, 32'd15);
    chk("b2b_r", dif.remainder, 32'd2);
    start_op(1'b0, 32'h0000_FFFF, 32'd3);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_done", 32'(dif.done), 32'd0);
    chk("abort_q", dif.quotient, 32'd0);
    chk("abort_r", dif.remainder, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) rst_n = 1'b1;
      if (dif.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    start_op(1'b0, 32'd9, 32'd3);
    wait_done(lat, nb);
    chk("post_rst_lat", 32'(lat), 32'd33);
    chk("post_rst_q", dif.quotient, 32'd3);
    chk("post_rst_r", dif.remainder, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
